// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer
//
// Owns the program counter and instruction register and steps each
// instruction through the state machine. The decoder flags are latched once
// per instruction in DECODE and then turned into single-cycle strobes.
// Data-memory accesses use a req/ack handshake guarded by a wait watchdog.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_start      launch request, sampled only in IDLE/HALTED
//   i_instr      instruction ROM data (combinational from o_pc)
//   i_branch     decoder: branch
//   i_mem_read   decoder: load
//   i_mem_write  decoder: store
//   i_reg_write  decoder: register-file write
//   i_br_taken   branch condition, valid in EXEC
//   i_br_target  branch target, valid in EXEC
//   i_mem_ack    data-memory completion
//   o_pc         program counter
//   o_ir         instruction register
//   o_op         opcode field of o_ir, drives the decoder
//   o_reg_wr_en  register-file write strobe
//   o_mem_req    data-memory request (level)
//   o_mem_we     store qualifier for o_mem_req
//   o_busy       high outside IDLE and HALTED
//   o_done       one-cycle pulse on entry to HALTED
//   o_error      sticky memory-timeout flag
//   o_cycle_cnt  saturating busy-cycle counter

module instr_sequencer #(
  parameter int              PW         = 10,
  parameter int              IW         = 9,
  parameter int              OPW        = 3,
  parameter logic [IW-1:0]   HALT_INSTR = {IW{1'b1}},
  parameter int              TIMEOUT    = 15
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_start,
  input  logic [IW-1:0]  i_instr,
  input  logic           i_branch,
  input  logic           i_mem_read,
  input  logic           i_mem_write,
  input  logic           i_reg_write,
  input  logic           i_br_taken,
  input  logic [PW-1:0]  i_br_target,
  input  logic           i_mem_ack,
  output logic [PW-1:0]  o_pc,
  output logic [IW-1:0]  o_ir,
  output logic [OPW-1:0] o_op,
  output logic           o_reg_wr_en,
  output logic           o_mem_req,
  output logic           o_mem_we,
  output logic           o_busy,
  output logic           o_done,
  output logic           o_error,
  output logic [15:0]    o_cycle_cnt
);

  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALTED
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_pc;
  logic [IW-1:0] r_ir;
  logic          r_branch;
  logic          r_mem_read;
  logic          r_mem_write;
  logic          r_reg_write;
  logic [WW-1:0] r_wait;
  logic          r_done;
  logic          r_error;
  logic [15:0]   r_cycle_cnt;

  logic          w_busy;
  logic [PW-1:0] w_pc_inc;
  logic [WW-1:0] w_wait_nxt;
  logic          w_alu_exec;

  assign w_busy     = (r_state != S_IDLE) && (r_state != S_HALTED);
  assign w_pc_inc   = r_pc + PW'(1);
  assign w_wait_nxt = r_wait + WW'(1);
  // Plain ALU instruction in EXEC: neither branch nor any memory flag.
  assign w_alu_exec = (r_state == S_EXEC) && !r_branch && !r_mem_read && !r_mem_write;

  // Strobes come from state and latched flags only, so the async reset of
  // r_state drops them immediately. WB is reached only by pure loads, which
  // keeps a read+write instruction from ever asserting the write strobe.
  assign o_reg_wr_en = r_reg_write && (w_alu_exec || (r_state == S_WB));
  assign o_mem_req   = (r_state == S_MEM);
  assign o_mem_we    = o_mem_req && r_mem_write;

  assign o_pc        = r_pc;
  assign o_ir        = r_ir;
  assign o_op        = r_ir[IW-1 -: OPW];
  assign o_busy      = w_busy;
  assign o_done      = r_done;
  assign o_error     = r_error;
  assign o_cycle_cnt = r_cycle_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_ir        <= '0;
      r_branch    <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_reg_write <= 1'b0;
      r_wait      <= '0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_cycle_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_busy && (r_cycle_cnt != 16'hFFFF)) begin
        r_cycle_cnt <= r_cycle_cnt + 16'd1;
      end

      case (r_state)
        S_IDLE, S_HALTED: begin
          if (i_start) begin
            r_pc        <= '0;
            r_cycle_cnt <= '0;
            r_error     <= 1'b0;
            r_state     <= S_FETCH;
          end
        end

        S_FETCH: begin
          r_ir <= i_instr;
          if (i_instr == HALT_INSTR) begin
            r_done  <= 1'b1;
            r_state <= S_HALTED;
          end else begin
            r_state <= S_DECODE;
          end
        end

        S_DECODE: begin
          r_branch    <= i_branch;
          r_mem_read  <= i_mem_read;
          r_mem_write <= i_mem_write;
          r_reg_write <= i_reg_write;
          r_state     <= S_EXEC;
        end

        S_EXEC: begin
          if (r_branch) begin
            r_pc    <= i_br_taken ? i_br_target : w_pc_inc;
            r_state <= S_FETCH;
          end else if (r_mem_read || r_mem_write) begin
            r_wait  <= '0;
            r_state <= S_MEM;
          end else begin
            r_pc    <= w_pc_inc;
            r_state <= S_FETCH;
          end
        end

        S_MEM: begin
          // An ack wins over the watchdog even on the edge it would expire.
          if (i_mem_ack) begin
            if (r_mem_write) begin
              r_pc    <= w_pc_inc;
              r_state <= S_FETCH;
            end else begin
              r_state <= S_WB;
            end
          end else begin
            r_wait <= w_wait_nxt;
            if (w_wait_nxt == WW'(TIMEOUT)) begin
              r_error <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_HALTED;
            end
          end
        end

        S_WB: begin
          r_pc    <= w_pc_inc;
          r_state <= S_FETCH;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - scoreboard bench for instr_sequencer
module tb_instr_sequencer;

  localparam int PW  = 10;
  localparam int IW  = 9;
  localparam int OPW = 3;

  localparam logic [IW-1:0] I_ALUW = 9'h000;
  localparam logic [IW-1:0] I_ALU  = 9'h040;
  localparam logic [IW-1:0] I_BR   = 9'h080;
  localparam logic [IW-1:0] I_LD   = 9'h0C0;
  localparam logic [IW-1:0] I_ST   = 9'h100;
  localparam logic [IW-1:0] I_RW   = 9'h140;
  localparam logic [IW-1:0] I_HALT = 9'h1FF;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic [IW-1:0] instr;
  logic branch, mem_read, mem_write, reg_write;
  logic br_taken;
  logic [PW-1:0] br_target;
  logic mem_ack;
  logic [PW-1:0] o_pc;
  logic [IW-1:0] o_ir;
  logic [OPW-1:0] o_op;
  logic o_reg_wr_en, o_mem_req, o_mem_we, o_busy, o_done, o_error;
  logic [15:0] o_cycle_cnt;

  logic [IW-1:0] rom [0:1023];
  logic [PW-1:0] tgt [0:1023];
  logic          tkn [0:1023];

  logic ack_r = 1'b0;
  logic ack_force = 1'b0;
  int   ack_delay = 1000;
  int   req_cyc = 0;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;
  int t0;

  typedef struct {
    string       name;
    logic [63:0] val;
  } ev_t;
  ev_t q[$];

  always #5 clk = ~clk;

  assign instr     = rom[o_pc];
  assign br_target = tgt[o_pc];
  assign br_taken  = tkn[o_pc];
  assign mem_ack   = ack_r | ack_force;

  always_comb begin
    branch = 1'b0; mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0;
    case (o_op)
      3'd0: reg_write = 1'b1;
      3'd2: begin branch = 1'b1; reg_write = 1'b1; end
      3'd3: begin mem_read = 1'b1; reg_write = 1'b1; end
      3'd4: mem_write = 1'b1;
      3'd5: begin mem_read = 1'b1; mem_write = 1'b1; reg_write = 1'b1; end
      default: ;
    endcase
  end

  instr_sequencer #(.PW(PW), .IW(IW), .OPW(OPW), .HALT_INSTR(9'h1FF), .TIMEOUT(15)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_instr(instr),
    .i_branch(branch), .i_mem_read(mem_read), .i_mem_write(mem_write),
    .i_reg_write(reg_write), .i_br_taken(br_taken), .i_br_target(br_target),
    .i_mem_ack(mem_ack), .o_pc(o_pc), .o_ir(o_ir), .o_op(o_op),
    .o_reg_wr_en(o_reg_wr_en), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_cycle_cnt(o_cycle_cnt)
  );

  function automatic logic [63:0] pk(input int c, input int p);
    return {c, p};
  endfunction

  task automatic push_ev(input string n, input int c, input int p);
    ev_t e;
    e.name = n;
    e.val  = pk(c, p);
    q.push_back(e);
  endtask

  task automatic push_done(input int c, input int pc, input int err, input int cnt);
    push_ev("done", c, err * 2048 + pc);
    push_ev("cnt", c, cnt);
  endtask

  task automatic check(input string n, input logic [63:0] a, input logic [63:0] e);
    n_total++;
    if (a === e) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", n, a, e);
  endtask

  task automatic got(input string n, input logic [63:0] v);
    ev_t e;
    n_total++;
    if (q.size() == 0) begin
      $display("FAIL unexpected %s actual=%h required=none", n, v);
    end else begin
      e = q.pop_front();
      if (e.name == n && e.val == v) n_pass++;
      else $display("FAIL event %s (expected %s) actual=%h required=%h", n, e.name, v, e.val);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drain(input int max);
    for (int i = 0; i < max && q.size() != 0; i++) tick();
    repeat (3) tick();
    check("drain", 64'(q.size()), 64'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // Memory responder: ack after ack_delay low cycles of a request.
  initial begin
    forever begin
      @(negedge clk);
      if (o_mem_req) begin
        ack_r = (req_cyc == ack_delay);
        req_cyc++;
      end else begin
        ack_r = 1'b0;
        req_cyc = 0;
      end
    end
  end

  // Monitor: turns observed DUT activity into events and scores them.
  initial begin
    logic [PW-1:0] m_prev_pc;
    int m_len;
    int m_we;
    m_prev_pc = '0;
    m_len = 0;
    m_we = 0;
    forever begin
      @(negedge clk);
      if (o_pc != m_prev_pc) got("pc", pk(cyc, int'(o_pc)));
      m_prev_pc = o_pc;
      if (o_reg_wr_en) got("wr", pk(cyc, int'(o_pc)));
      if (o_mem_req) begin
        m_len++;
        if (o_mem_we) m_we++;
      end else begin
        if (m_len != 0) got("req", pk(cyc, m_len * 256 + m_we));
        m_len = 0;
        m_we = 0;
      end
      if (o_done) begin
        got("done", pk(cyc, int'({o_error, o_busy, o_pc})));
        got("cnt", pk(cyc, int'(o_cycle_cnt)));
      end
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      rom[i] = I_HALT;
      tgt[i] = '0;
      tkn[i] = 1'b0;
    end
    #1 rst_n = 1'b0;
    repeat (2) tick();
    check("rst_pc", 64'(o_pc), 64'd0);
    check("rst_ir", 64'(o_ir), 64'd0);
    check("rst_op", 64'(o_op), 64'd0);
    check("rst_regwr", 64'(o_reg_wr_en), 64'd0);
    check("rst_memreq", 64'(o_mem_req), 64'd0);
    check("rst_memwe", 64'(o_mem_we), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_done", 64'(o_done), 64'd0);
    check("rst_error", 64'(o_error), 64'd0);
    check("rst_cnt", 64'(o_cycle_cnt), 64'd0);
    rst_n = 1'b1;
    repeat (2) tick();
    check("idle_busy", 64'(o_busy), 64'd0);

    // ALU write then halt
    rom[0] = I_ALUW; rom[1] = I_HALT;
    t0 = cyc + 1;
    push_ev("wr", t0 + 2, 0);
    push_ev("pc", t0 + 3, 1);
    push_done(t0 + 4, 1, 0, 4);
    go();
    drain(40);

    // Branch taken 0->5->2, then halt
    rom[0] = I_BR; tgt[0] = 10'd5; tkn[0] = 1'b1;
    rom[5] = I_BR; tgt[5] = 10'd2; tkn[5] = 1'b1;
    rom[2] = I_HALT;
    t0 = cyc + 1;
    push_ev("pc", t0, 0);
    push_ev("pc", t0 + 3, 5);
    push_ev("pc", t0 + 6, 2);
    push_done(t0 + 7, 2, 0, 7);
    go();
    drain(40);

    // Same branch at 5 not taken -> 6
    tkn[5] = 1'b0;
    t0 = cyc + 1;
    push_ev("pc", t0, 0);
    push_ev("pc", t0 + 3, 5);
    push_ev("pc", t0 + 6, 6);
    push_done(t0 + 7, 6, 0, 7);
    go();
    drain(40);

    // Load, ack after 2 low cycles
    rom[0] = I_LD; rom[1] = I_HALT; ack_delay = 2;
    t0 = cyc + 1;
    push_ev("pc", t0, 0);
    push_ev("wr", t0 + 6, 0);
    push_ev("req", t0 + 6, 3 * 256 + 0);
    push_ev("pc", t0 + 7, 1);
    push_done(t0 + 8, 1, 0, 8);
    go();
    drain(40);

    // Store with immediate ack, then read+write treated as store
    rom[0] = I_ST; rom[1] = I_RW; rom[2] = I_HALT; ack_delay = 0;
    t0 = cyc + 1;
    push_ev("pc", t0, 0);
    push_ev("pc", t0 + 4, 1);
    push_ev("req", t0 + 4, 256 + 1);
    push_ev("pc", t0 + 8, 2);
    push_ev("req", t0 + 8, 256 + 1);
    push_done(t0 + 9, 2, 0, 9);
    go();
    drain(40);

    // Ack on the very edge the watchdog would expire: still an ack
    rom[0] = I_ST; rom[1] = I_HALT; ack_delay = 14;
    t0 = cyc + 1;
    push_ev("pc", t0, 0);
    push_ev("pc", t0 + 18, 1);
    push_ev("req", t0 + 18, 15 * 256 + 15);
    push_done(t0 + 19, 1, 0, 19);
    go();
    drain(60);

    // Store never acked: timeout, error, PC held
    rom[0] = I_ALU; rom[1] = I_ST; ack_delay = 1000;
    t0 = cyc + 1;
    push_ev("pc", t0, 0);
    push_ev("pc", t0 + 3, 1);
    push_ev("req", t0 + 21, 15 * 256 + 15);
    push_done(t0 + 21, 1, 1, 21);
    go();
    drain(60);
    check("error_sticky", 64'(o_error), 64'd1);

    // Restart clears error; immediate halt
    rom[0] = I_HALT;
    t0 = cyc + 1;
    push_ev("pc", t0, 0);
    push_done(t0 + 1, 0, 0, 1);
    go();
    check("error_cleared", 64'(o_error), 64'd0);
    drain(20);

    // PC wrap at 2^PW-1
    rom[0] = I_BR; tgt[0] = 10'd1023; tkn[0] = 1'b1;
    rom[1023] = I_ALUW;
    t0 = cyc + 1;
    push_ev("pc", t0 + 3, 1023);
    push_ev("wr", t0 + 5, 1023);
    push_ev("pc", t0 + 6, 0);
    push_done(t0 + 7, 0, 0, 7);
    go();
    repeat (3) tick();
    rom[0] = I_HALT;
    drain(40);

    // Tight loop BrTarget==PC, counter saturation
    rom[0] = I_BR; tgt[0] = 10'd0; tkn[0] = 1'b1;
    go();
    repeat (100) tick();
    check("cnt_100", 64'(o_cycle_cnt), 64'd100);
    repeat (65434) tick();
    check("cnt_fffe", 64'(o_cycle_cnt), 64'hFFFE);
    tick();
    check("cnt_ffff", 64'(o_cycle_cnt), 64'hFFFF);
    repeat (4465) tick();
    check("cnt_sat", 64'(o_cycle_cnt), 64'hFFFF);
    check("loop_busy", 64'(o_busy), 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("loop_rst_busy", 64'(o_busy), 64'd0);
    drain(5);

    // Reset in the middle of MEM
    rom[0] = I_LD; ack_delay = 1000;
    t0 = cyc + 1;
    push_ev("req", t0 + 5, 2 * 256 + 0);
    go();
    repeat (4) tick();
    check("pre_rst_req", 64'(o_mem_req), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mr_req", 64'(o_mem_req), 64'd0);
    check("mr_we", 64'(o_mem_we), 64'd0);
    check("mr_regwr", 64'(o_reg_wr_en), 64'd0);
    check("mr_busy", 64'(o_busy), 64'd0);
    check("mr_ir", 64'(o_ir), 64'd0);
    check("mr_cnt", 64'(o_cycle_cnt), 64'd0);
    check("mr_done", 64'(o_done), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("mr_idle", 64'(o_busy), 64'd0);
    drain(10);

    // Start held while busy and MemAck outside MEM are ignored
    rom[0] = I_ALU; rom[1] = I_HALT; ack_force = 1'b1;
    t0 = cyc + 1;
    push_ev("pc", t0 + 3, 1);
    push_done(t0 + 4, 1, 0, 4);
    go();
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    drain(40);
    ack_force = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
